// File: rtl/rsa_stream_ctrl.sv
// Byte-stream sequencer for one Rsa256Core: loads N/D once, then streams
// cipher blocks in over rx and plaintext blocks out over tx.
module rsa_stream_ctrl #(
   parameter int KEY_BYTES = 32,
   parameter int OUT_BYTES = 31,
   parameter int TO_W      = 21
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [7:0]   i_rx_data,
   input  logic         i_rx_valid,
   output logic         o_rx_ready,
   output logic [7:0]   o_tx_data,
   output logic         o_tx_valid,
   input  logic         i_tx_ready,
   input  logic         i_key_reload,
   output logic         o_core_start,
   output logic [255:0] o_core_a,
   output logic [255:0] o_core_d,
   output logic [255:0] o_core_n,
   input  logic [269:0] i_core_result,
   input  logic         i_core_finished,
   output logic         o_busy,
   output logic         o_timeout
);

   localparam int OW = 8 * OUT_BYTES;
   localparam int CW = $clog2((KEY_BYTES > OUT_BYTES ? KEY_BYTES : OUT_BYTES) + 1);
   localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   localparam logic [2:0] S_GET_N = 3'd0;
   localparam logic [2:0] S_GET_D = 3'd1;
   localparam logic [2:0] S_GET_A = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_SEND  = 3'd5;

   logic [2:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [255:0]    n_q, n_d, d_q, d_d, a_q, a_d;
   logic [OW-1:0]   tx_q, tx_d;
   logic [TO_W-1:0] wdog_q, wdog_d;
   logic            to_q, to_d;
   logic            rl_q, rl_d;
   logic            rx_fire, key_last, rl_req;
   logic            unused_res;

   assign rx_fire    = i_rx_valid && o_rx_ready;
   assign key_last   = (cnt_q == CW'(KEY_BYTES - 1));
   assign rl_req     = rl_q || i_key_reload;
   assign unused_res = ^i_core_result[269:OW];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      d_d     = d_q;
      a_d     = a_q;
      tx_d    = tx_q;
      wdog_d  = wdog_q;
      to_d    = to_q;
      rl_d    = rl_req;
      case (state_q)
         S_GET_N, S_GET_D: begin
            if (rx_fire) begin
               if (state_q == S_GET_N) n_d = {n_q[247:0], i_rx_data};
               else                    d_d = {d_q[247:0], i_rx_data};
               cnt_d = cnt_q + 1'b1;
               if (key_last) begin
                  cnt_d   = '0;
                  state_d = (state_q == S_GET_N) ? S_GET_D : S_GET_A;
               end
            end
         end
         S_GET_A: begin
            // A pending reload wins over a partial cipher block, which is dropped.
            if (rl_req) begin
               state_d = S_GET_N;
            end else if (rx_fire) begin
               a_d   = {a_q[247:0], i_rx_data};
               cnt_d = cnt_q + 1'b1;
               if (key_last) begin
                  cnt_d   = '0;
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            wdog_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i_core_finished) begin
               tx_d    = i_core_result[OW-1:0];
               state_d = S_SEND;
            end else if (wdog_q == WD_LAST) begin
               to_d    = 1'b1;
               state_d = S_GET_A;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_SEND: begin
            if (i_tx_ready) begin
               tx_d  = {tx_q[OW-9:0], 8'h00};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(OUT_BYTES - 1)) begin
                  cnt_d   = '0;
                  state_d = rl_req ? S_GET_N : S_GET_A;
               end
            end
         end
         default: state_d = S_GET_N;
      endcase
      // Every path into S_GET_N starts a fresh key load.
      if (state_d == S_GET_N && state_q != S_GET_N) begin
         rl_d  = 1'b0;
         cnt_d = '0;
         to_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_GET_N;
         cnt_q   <= '0;
         n_q     <= '0;
         d_q     <= '0;
         a_q     <= '0;
         tx_q    <= '0;
         wdog_q  <= '0;
         to_q    <= 1'b0;
         rl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         d_q     <= d_d;
         a_q     <= a_d;
         tx_q    <= tx_d;
         wdog_q  <= wdog_d;
         to_q    <= to_d;
         rl_q    <= rl_d;
      end
   end

   assign o_rx_ready   = (state_q == S_GET_N) || (state_q == S_GET_D) || (state_q == S_GET_A);
   assign o_core_start = (state_q == S_START);
   assign o_busy       = (state_q == S_START) || (state_q == S_WAIT);
   assign o_tx_valid   = (state_q == S_SEND);
   assign o_tx_data    = tx_q[OW-1 -: 8];
   assign o_timeout    = to_q;
   assign o_core_a     = a_q;
   assign o_core_d     = d_q;
   assign o_core_n     = n_q;

endmodule
